// File: rtl/image_pipe_src.sv
// Test-pattern frame source for the image_pipe stream: one frame of frame_len beats per start.
// Registered outputs; start-to-valid 1 cycle; busy_in stalls data/valid/beat_cnt and end_out.
module image_pipe_src #(
    parameter int             DW    = 16,
    parameter int             LEN_W = 16,
    parameter logic [DW-1:0]  POLY  = 16'hB400
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [1:0]       mode,
    input  logic [DW-1:0]    seed,
    output logic [DW-1:0]    image_pipe_data_out,
    output logic             image_pipe_valid_out,
    output logic             image_pipe_end_out,
    input  logic             image_pipe_busy_in,
    output logic             active,
    output logic             done,
    output logic [LEN_W-1:0] beat_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_EOF} state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic [DW-1:0]    r_data, w_data_nxt, w_pattern_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_end, w_end_nxt;
    logic             r_done, w_done_nxt;
    logic             r_active;
    logic             w_xfer;

    assign w_xfer = r_valid & ~image_pipe_busy_in;

    // Reserved mode 3 falls into the default and behaves as constant.
    always_comb begin
        w_pattern_nxt = r_data;
        case (r_mode)
            2'd0:    w_pattern_nxt = r_data + DW'(1);
            2'd2:    w_pattern_nxt = (r_data >> 1) ^ (r_data[0] ? POLY : '0);
            default: w_pattern_nxt = r_data;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_mode_nxt  = r_mode;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_end_nxt   = r_end;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                w_end_nxt   = 1'b0;
                if (start && !abort) begin
                    w_len_nxt  = frame_len;
                    w_mode_nxt = mode;
                    w_data_nxt = seed;
                    w_cnt_nxt  = '0;
                    if (frame_len != '0) begin
                        w_state_nxt = ST_SEND;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_EOF;
                        w_end_nxt   = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_end_nxt   = 1'b0;
                end else if (w_xfer) begin
                    w_cnt_nxt = r_cnt + LEN_W'(1);
                    if (r_cnt == r_len - LEN_W'(1)) begin
                        w_state_nxt = ST_EOF;
                        w_valid_nxt = 1'b0;
                        w_end_nxt   = 1'b1;
                    end else begin
                        w_data_nxt = w_pattern_nxt;
                    end
                end
            end
            ST_EOF: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_end_nxt   = 1'b0;
                end else if (r_end && !image_pipe_busy_in) begin
                    w_state_nxt = ST_IDLE;
                    w_end_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_end_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_mode   <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_end    <= 1'b0;
            r_done   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_mode   <= w_mode_nxt;
            r_data   <= w_data_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_end    <= w_end_nxt;
            r_done   <= w_done_nxt;
            r_active <= (w_state_nxt != ST_IDLE);
        end
    end

    assign image_pipe_data_out  = r_data;
    assign image_pipe_valid_out = r_valid;
    assign image_pipe_end_out   = r_end;
    assign active               = r_active;
    assign done                 = r_done;
    assign beat_cnt             = r_cnt;

endmodule

// File: tb/tb_image_pipe_src.sv
// Bench for image_pipe_src: directed scenarios plus a random-backpressure frame scoreboard.
module tb_image_pipe_src;

    logic        clk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] frame_len = '0;
    logic [1:0]  mode = '0;
    logic [15:0] seed = '0;
    logic        busy = 1'b0;
    logic [15:0] data;
    logic        valid;
    logic        endo;
    logic        active;
    logic        done;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    image_pipe_src dut (
        .clk                  (clk),
        .s_rst_n              (s_rst_n),
        .start                (start),
        .abort                (abort),
        .frame_len            (frame_len),
        .mode                 (mode),
        .seed                 (seed),
        .image_pipe_data_out  (data),
        .image_pipe_valid_out (valid),
        .image_pipe_end_out   (endo),
        .image_pipe_busy_in   (busy),
        .active               (active),
        .done                 (done),
        .beat_cnt             (cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    // A beat transfers on the next rising edge when it is valid, not stalled, not aborted.
    always @(negedge clk) begin
        if (s_rst_n && valid && !busy && !abort) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got %h exp none", data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    errors++;
                    $display("FAIL sb_data got %h exp %h", data, e);
                end
            end
        end
    end

    function automatic logic [15:0] model_next(input logic [15:0] d, input logic [1:0] m);
        case (m)
            2'd0:    return d + 16'd1;
            2'd2:    return (d >> 1) ^ (d[0] ? 16'hB400 : 16'h0000);
            default: return d;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] len, input logic [1:0] m, input logic [15:0] sd);
        logic [15:0] d;
        d = sd;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(d);
            d = model_next(d, m);
        end
        frame_len = len;
        mode      = m;
        seed      = sd;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input bit rnd, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            busy = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (done) seen = 1'b1;
        end
        busy = 1'b0;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        tick();
        tick();
        checks++; if (data !== 16'h0)  begin errors++; $display("FAIL rst_data got %h exp 0000", data); end
        checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got %b exp 0", valid); end
        checks++; if (endo !== 1'b0)   begin errors++; $display("FAIL rst_end got %b exp 0", endo); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active got %b exp 0", active); end
        checks++; if (cnt !== 16'h0)   begin errors++; $display("FAIL rst_cnt got %0d exp 0", cnt); end
        s_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_incr();
        start_frame(16'd4, 2'd0, 16'h0010);
        for (int i = 0; i < 4; i++) begin
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL t1_valid beat %0d got %b exp 1", i, valid); end
            checks++; if (data !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL t1_data got %h exp %h", data, 16'h0010 + 16'(i)); end
            if (i < 3) tick();
        end
        tick();
        checks++; if (valid !== 1'b0 || endo !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL t1_eof got v%b e%b d%b exp v0 e1 d0", valid, endo, done); end
        tick();
        checks++; if (endo !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL t1_done got e%b d%b exp e0 d1", endo, done); end
        checks++; if (cnt !== 16'd4 || active !== 1'b0) begin errors++; $display("FAIL t1_cnt got %0d act %b exp 4 act 0", cnt, active); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t1_left got %0d exp 0", exp_q.size()); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_backpressure();
        start_frame(16'd3, 2'd0, 16'hFFFE);
        tick();
        tick();
        checks++; if (data !== 16'h0000 || valid !== 1'b1) begin errors++; $display("FAIL t2_wrap got %h v%b exp 0000 v1", data, valid); end
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (data !== 16'h0000 || valid !== 1'b1 || cnt !== 16'd2) begin errors++; $display("FAIL t2_hold got %h v%b c%0d exp 0000 v1 c2", data, valid, cnt); end
        end
        busy = 1'b0;
        tick();
        checks++; if (endo !== 1'b1 || cnt !== 16'd3) begin errors++; $display("FAIL t2_eof got e%b c%0d exp e1 c3", endo, cnt); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL t2_done got %b exp 1", done); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t2_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_zero_len();
        start_frame(16'd0, 2'd0, 16'h1234);
        checks++; if (valid !== 1'b0 || endo !== 1'b1 || active !== 1'b1) begin errors++; $display("FAIL t3_eof got v%b e%b a%b exp v0 e1 a1", valid, endo, active); end
        busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (endo !== 1'b1 || valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t3_hold got e%b v%b d%b exp e1 v0 d0", endo, valid, done); end
        end
        busy = 1'b0;
        tick();
        checks++; if (endo !== 1'b0 || done !== 1'b1 || cnt !== 16'd0) begin errors++; $display("FAIL t3_done got e%b d%b c%0d exp e0 d1 c0", endo, done, cnt); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t3_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_lfsr();
        bit seen;
        start_frame(16'd3, 2'd2, 16'h0001);
        run_to_done(20, 1'b0, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t4_done got none exp pulse"); end
        checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL t4_cnt got %0d exp 3", cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t4_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_abort_reset();
        start_frame(16'd8, 2'd0, 16'h0100);
        frame_len = 16'd2;
        mode      = 2'd1;
        seed      = 16'h5555;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++; if (cnt !== 16'd3 || data !== 16'h0103) begin errors++; $display("FAIL t5_mid got c%0d %h exp c3 0103", cnt, data); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (valid !== 1'b0 || endo !== 1'b0 || done !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL t5_abort got v%b e%b d%b a%b exp 0000", valid, endo, done, active); end
        checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL t5_abort_cnt got %0d exp 3", cnt); end
        checks++; if (exp_q.size() != 5) begin errors++; $display("FAIL t5_left got %0d exp 5", exp_q.size()); end
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (endo !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL t5_quiet got e%b d%b v%b exp 000", endo, done, valid); end
        end
        start_frame(16'd5, 2'd0, 16'h0040);
        tick();
        tick();
        s_rst_n = 1'b0;
        tick();
        checks++; if (data !== 16'h0 || valid !== 1'b0 || endo !== 1'b0 || done !== 1'b0 || active !== 1'b0 || cnt !== 16'h0) begin
            errors++; $display("FAIL t5_rst got %h v%b e%b d%b a%b c%0d exp all 0", data, valid, endo, done, active, cnt);
        end
        s_rst_n = 1'b1;
        exp_q.delete();
        tick();
        checks++; if (active !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t5_post_rst got a%b d%b exp a0 d0", active, done); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        start_frame(16'd1, 2'd0, 16'h0033);
        run_to_done(20, 1'b0, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t6_first_done got none exp pulse"); end
        start_frame(16'd2, 2'd1, 16'h00AA);
        checks++; if (valid !== 1'b1 || data !== 16'h00AA || active !== 1'b1) begin errors++; $display("FAIL t6_b2b got v%b %h a%b exp v1 00aa a1", valid, data, active); end
        run_to_done(20, 1'b0, seen);
        checks++; if (!seen || cnt !== 16'd2) begin errors++; $display("FAIL t6_second got seen%b c%0d exp seen1 c2", seen, cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL t6_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_random();
        bit          seen;
        logic [15:0] len;
        for (int f = 0; f < 1000; f++) begin
            len  = 16'($urandom_range(0, 6));
            busy = 1'($urandom_range(0, 1));
            start_frame(len, 2'($urandom_range(0, 3)), 16'($urandom));
            run_to_done(100, 1'b1, seen);
            checks++; if (!seen) begin errors++; $display("FAIL rnd_done frame %0d got none exp pulse", f); end
            checks++; if (cnt !== len) begin errors++; $display("FAIL rnd_cnt frame %0d got %0d exp %0d", f, cnt, len); end
            checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_left frame %0d got %0d exp 0", f, exp_q.size()); exp_q.delete(); end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_backpressure();
        test_zero_len();
        test_lfsr();
        test_abort_reset();
        test_back_to_back();
        test_random();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
